// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// selects the next PC from execute-unit results and produces the commit strobe.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] branch_base_addr,
    output logic [31:0] link_addr,
    output logic        instr_valid,
    output logic        commit,
    input  logic        stall,
    input  logic [31:0] Addr_result,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    output logic        fetch_fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] link_q, link_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] next_pc;
    logic        take_br;
    logic        req;

    // Next-PC selection: Jr, then j/jal, then taken branch, then sequential.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        jump_tgt = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        take_br  = (Branch & Zero) | (nBranch & ~Zero);
        if (Jr)
            next_pc = Read_data_1;
        else if (Jmp | Jal)
            next_pc = jump_tgt;
        else if (take_br)
            next_pc = Addr_result;
        else
            next_pc = pc_plus4;
    end

    // FSM next-state and handshake/commit outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        link_d      = link_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        code_d      = code_q;
        req         = 1'b0;
        instr_valid = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    code_d  = 2'b01;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    commit = 1'b1;
                    // A misaligned target still retires the instruction but
                    // leaves PC and link untouched.
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        code_d  = 2'b10;
                        state_d = S_FAULT;
                    end else begin
                        pc_d = next_pc;
                        if (Jal)
                            link_d = pc_plus4;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FAULT: begin
            end
            default: state_d = S_FAULT;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            link_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // Request is masked while reset is held so memory sees no fetch.
    assign imem_req         = req & rst_n;
    assign imem_addr        = pc_q;
    assign Instruction      = instr_q;
    assign PC               = pc_q;
    assign branch_base_addr = pc_plus4;
    assign link_addr        = link_q;
    assign fetch_fault      = fault_q;
    assign fault_code       = code_q;

endmodule
